// File: rtl/lcd_instr_driver.sv
// HD44780 8-bit parallel bus driver: runs the power-up init sequence, then
// issues accepted {RS, D[7:0]} instructions with setup / E-pulse / hold / execution-wait timing.
module lcd_instr_driver #(
   parameter int PWRUP_WAIT_CYC = 750000,
   parameter int EN_PULSE_CYC   = 25,
   parameter int CMD_WAIT_CYC   = 2500,
   parameter int CLR_WAIT_CYC   = 82000
) (
   input  logic       clk,
   input  logic       rst,
   // valid/ready: an instruction transfers on a rising clk edge where
   // instr_valid and instr_ready are both 1; instr is sampled only on that edge.
   input  logic [8:0] instr,
   input  logic       instr_valid,
   output logic       instr_ready,
   output logic       init_done,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [2:0] dbg_state
);

   localparam int MAX_A    = (PWRUP_WAIT_CYC > EN_PULSE_CYC) ? PWRUP_WAIT_CYC : EN_PULSE_CYC;
   localparam int MAX_B    = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
   localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW       = $clog2(MAX_WAIT) + 1;

   typedef enum logic [2:0] {
      S_PWRUP = 3'd0,
      S_SETUP = 3'd1,
      S_EN    = 3'd2,
      S_HOLD  = 3'd3,
      S_WAIT  = 3'd4,
      S_IDLE  = 3'd5
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    step, step_n;
   logic          en_n, rs_n, ready_n, done_n;
   logic [7:0]    data_n;
   logic          long_wait;

   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_rom = 8'h38;
         3'd3:             init_rom = 8'h0C;
         3'd4:             init_rom = 8'h01;
         3'd5:             init_rom = 8'h06;
         default:          init_rom = 8'h00;
      endcase
   endfunction

   // Clear and home need the long execution wait; the bus still holds the instruction.
   assign long_wait = ({lcd_rs, lcd_data} == 9'h001) || ({lcd_rs, lcd_data} == 9'h002);
   assign lcd_rw    = 1'b0;
   assign dbg_state = state;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      step_n  = step;
      en_n    = lcd_en;
      rs_n    = lcd_rs;
      data_n  = lcd_data;
      ready_n = instr_ready;
      done_n  = init_done;
      case (state)
         S_PWRUP: begin
            // Reset clears the counter, so power-up counts up to its limit.
            if (cnt == CW'(PWRUP_WAIT_CYC - 1)) begin
               state_n = S_SETUP;
               step_n  = 3'd0;
               rs_n    = 1'b0;
               data_n  = init_rom(3'd0);
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_SETUP: begin
            state_n = S_EN;
            en_n    = 1'b1;
            cnt_n   = CW'(EN_PULSE_CYC - 1);
         end
         S_EN: begin
            if (cnt == '0) begin
               state_n = S_HOLD;
               en_n    = 1'b0;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         S_HOLD: begin
            state_n = S_WAIT;
            cnt_n   = long_wait ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
         end
         S_WAIT: begin
            if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else if (!init_done && step != 3'd5) begin
               state_n = S_SETUP;
               step_n  = step + 3'd1;
               rs_n    = 1'b0;
               data_n  = init_rom(step + 3'd1);
            end else begin
               state_n = S_IDLE;
               ready_n = 1'b1;
               done_n  = 1'b1;
            end
         end
         S_IDLE: begin
            // 9'h000 is the mapper's "no char" code: consumed without a bus cycle.
            if (instr_valid && instr_ready && instr != 9'h000) begin
               state_n = S_SETUP;
               rs_n    = instr[8];
               data_n  = instr[7:0];
               ready_n = 1'b0;
            end
         end
         default: state_n = S_PWRUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_PWRUP;
         cnt         <= '0;
         step        <= 3'd0;
         lcd_en      <= 1'b0;
         lcd_rs      <= 1'b0;
         lcd_data    <= 8'h00;
         instr_ready <= 1'b0;
         init_done   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         step        <= step_n;
         lcd_en      <= en_n;
         lcd_rs      <= rs_n;
         lcd_data    <= data_n;
         instr_ready <= ready_n;
         init_done   <= done_n;
      end
   end

endmodule

// File: tb/tb_lcd_instr_driver.sv
// Bench for lcd_instr_driver: timeline model of bus writes checked every cycle,
// plus directed scenarios with hand-computed edge offsets.
module tb_lcd_instr_driver;

   localparam int PWRUP = 10;
   localparam int EN    = 2;
   localparam int CMD   = 5;
   localparam int CLR   = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] instr;
   logic       instr_valid;
   logic       instr_ready, init_done, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;

   lcd_instr_driver #(
      .PWRUP_WAIT_CYC(PWRUP), .EN_PULSE_CYC(EN), .CMD_WAIT_CYC(CMD), .CLR_WAIT_CYC(CLR)
   ) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .init_done(init_done), .lcd_data(lcd_data),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .dbg_state(dbg_state)
   );

   // ---------------- clock / edge index ----------------
   always #5 clk = ~clk;

   function automatic int eidx();
      return int'(($time - 5) / 10);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", name, eidx(), act, exp);
      end
   endtask

   // ---------------- model: timeline of bus writes ----------------
   logic [8:0] init_seq [6] = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
   bit         m_on = 0, m_rst_edge = 0, m_done = 0, m_ready = 0, m_en = 0;
   int         m_rst_e = 0, t = 0, ld_t = -1000, busy = 0, init_idx = 0;
   logic [8:0] m_instr = 9'h000;

   task automatic load(input logic [8:0] x);
      ld_t    = t;
      m_instr = x;
      busy    = 2 + EN + (((x == 9'h001) || (x == 9'h002)) ? CLR : CMD);
   endtask

   initial forever begin
      bit acc_ok;
      @(posedge clk);
      if (rst) begin
         m_on = 1; m_rst_edge = 1; m_rst_e = eidx();
         t = 0; ld_t = -1000; busy = 0; m_instr = 9'h000; init_idx = 0;
         m_done = 0; m_ready = 0; m_en = 0;
      end else if (m_on) begin
         m_rst_edge = 0;
         acc_ok = m_ready;
         t++;
         if (!m_done) begin
            if ((init_idx == 0 && t == PWRUP) || (init_idx > 0 && t == ld_t + busy)) begin
               if (init_idx == 6) m_done = 1;
               else begin
                  load(init_seq[init_idx]);
                  init_idx++;
               end
            end
         end else if (acc_ok && instr_valid && instr != 9'h000) begin
            load(instr);
         end
         m_en    = (t - ld_t >= 1) && (t - ld_t <= EN);
         m_ready = m_done && (t >= ld_t + busy);
      end
   end

   // ---------------- compare process + event log ----------------
   int en_rise_e[$], en_rise_v[$], en_len[$], rdy_rise_e[$], done_rise_e[$];
   logic p_en = 0, p_rdy = 0, p_done = 0;

   initial forever begin
      int k;
      @(negedge clk);
      if (m_on) begin
         k = eidx();
         chk("en",    32'(lcd_en),      32'(m_en));
         chk("rs",    32'(lcd_rs),      32'(m_instr[8]));
         chk("data",  32'(lcd_data),    32'(m_instr[7:0]));
         chk("ready", 32'(instr_ready), 32'(m_ready));
         chk("done",  32'(init_done),   32'(m_done));
         chk("rw",    32'(lcd_rw),      32'(0));
         if (m_rst_edge) begin
            en_rise_e.delete(); en_rise_v.delete(); en_len.delete();
            rdy_rise_e.delete(); done_rise_e.delete();
         end else begin
            if (lcd_en && !p_en) begin
               en_rise_e.push_back(k);
               en_rise_v.push_back(int'({lcd_rs, lcd_data}));
            end
            if (!lcd_en && p_en && en_rise_e.size() > 0) en_len.push_back(k - en_rise_e[$]);
            if (instr_ready && !p_rdy) rdy_rise_e.push_back(k);
            if (init_done && !p_done) done_rise_e.push_back(k);
         end
         p_en = lcd_en; p_rdy = instr_ready; p_done = init_done;
      end
   end

   function automatic int qget(input int q[$], input int i);
      if (i >= 0 && i < q.size()) return q[i];
      return -1;
   endfunction

   // ---------------- driver tasks (enter and leave just after a negedge) ----------------
   task automatic send(input logic [8:0] x, output int acc_e);
      int n = 0;
      while (!instr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready_timeout", 32'(n < 200), 32'(1));
      instr = x; instr_valid = 1'b1;
      @(posedge clk);
      acc_e = eidx();
      @(negedge clk);
      instr_valid = 1'b0;
      instr = 9'($urandom_range(0, 511));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Full init after a reset: pulse order/data, widths and rise offsets from the reset edge.
   task automatic check_init();
      int n = 0;
      int r0;
      logic [8:0] exp_v [6] = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
      while (!init_done && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("init_timeout", 32'(n < 400), 32'(1));
      @(negedge clk);
      r0 = m_rst_e;
      chk("init_pulse_count", 32'(en_rise_e.size()), 32'(6));
      for (int i = 0; i < 6; i++) begin
         chk("init_pulse_val", 32'(qget(en_rise_v, i)), 32'(exp_v[i]));
         chk("init_pulse_len", 32'(qget(en_len, i)), 32'(2));
      end
      chk("init_first_rise", 32'(qget(en_rise_e, 0) - r0), 32'(11));
      chk("init_gap_after_clear", 32'(qget(en_rise_e, 5) - qget(en_rise_e, 4)), 32'(24));
      chk("init_done_edge", 32'(qget(done_rise_e, 0) - r0), 32'(79));
      chk("init_ready_with_done", 32'(qget(rdy_rise_e, 0)), 32'(qget(done_rise_e, 0)));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int a, a0, b, eb, rb, n;
      logic [8:0] items [3] = '{9'h141, 9'h142, 9'h143};
      int acc [3];
      int idx;
      bit r;

      rst = 1'b1; instr = 9'h000; instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // 1: power-up init
      check_init();

      // 2: single data write
      eb = en_rise_e.size(); rb = rdy_rise_e.size();
      send(9'h141, a);
      idle(12);
      chk("s2_en_offset", 32'(qget(en_rise_e, eb) - a), 32'(1));
      chk("s2_value", 32'(qget(en_rise_v, eb)), 32'(9'h141));
      chk("s2_len", 32'(qget(en_len, eb)), 32'(2));
      chk("s2_ready_offset", 32'(qget(rdy_rise_e, rb) - a), 32'(9));

      // 3: clear display uses the long wait
      eb = en_rise_e.size(); rb = rdy_rise_e.size();
      send(9'h001, a);
      idle(28);
      chk("s3_value", 32'(qget(en_rise_v, eb)), 32'(9'h001));
      chk("s3_pulses", 32'(en_rise_e.size() - eb), 32'(1));
      chk("s3_ready_offset", 32'(qget(rdy_rise_e, rb) - a), 32'(24));

      // 4: no-char code is consumed without a bus cycle
      eb = en_rise_e.size();
      send(9'h000, a0);
      chk("s4_ready_kept", 32'(instr_ready), 32'(1));
      send(9'h141, b);
      chk("s4_back_to_back", 32'(b - a0), 32'(1));
      idle(12);
      chk("s4_pulses", 32'(en_rise_e.size() - eb), 32'(1));
      chk("s4_first_pulse_from_b", 32'(qget(en_rise_e, eb) - b), 32'(1));

      // 5: valid held high, instr scrambled while busy
      eb = en_rise_e.size(); rb = rdy_rise_e.size();
      idx = 0; n = 0;
      instr = items[0]; instr_valid = 1'b1;
      while (idx < 3 && n < 200) begin
         r = instr_ready;
         @(posedge clk);
         if (r) begin
            acc[idx] = eidx();
            idx++;
         end
         @(negedge clk);
         n++;
         if (instr_ready && idx < 3) instr = items[idx];
         else instr = 9'($urandom_range(0, 511));
      end
      instr_valid = 1'b0;
      chk("s5_accepts", 32'(idx), 32'(3));
      idle(12);
      chk("s5_pulses", 32'(en_rise_e.size() - eb), 32'(3));
      for (int i = 0; i < 3; i++) begin
         chk("s5_value", 32'(qget(en_rise_v, eb + i)), 32'(9'h141 + i));
         chk("s5_en_offset", 32'(qget(en_rise_e, eb + i) - acc[i]), 32'(1));
         chk("s5_ready_offset", 32'(qget(rdy_rise_e, rb + i) - acc[i]), 32'(9));
      end

      // 6: reset while the strobe is high
      send(9'h142, a);
      n = 0;
      while (!lcd_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("s6_en_seen", 32'(lcd_en), 32'(1));
      rst = 1'b1;
      @(negedge clk);
      chk("s6_en_low", 32'(lcd_en), 32'(0));
      chk("s6_done_low", 32'(init_done), 32'(0));
      chk("s6_ready_low", 32'(instr_ready), 32'(0));
      chk("s6_bus_cleared", 32'({lcd_rs, lcd_data}), 32'(0));
      rst = 1'b0;
      check_init();

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
